// File: rtl/program_loader_pkg.sv
// Purpose: shared constants for the program loader (sync bytes, widths, FSM encodings).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package program_loader_pkg;

    localparam int         DATA_WIDTH_DEF = 16;
    localparam int         ADDR_WIDTH_DEF = 8;
    localparam logic [7:0] MAGIC0_DEF     = 8'hA5;
    localparam logic [7:0] MAGIC1_DEF     = 8'h5A;

    // Encodings are kept numeric and ordered so the "frame in progress"
    // window (SYNC1..CSUM) is a contiguous range.
    localparam logic [3:0] ST_SYNC0   = 4'd0;
    localparam logic [3:0] ST_SYNC1   = 4'd1;
    localparam logic [3:0] ST_CNT_HI  = 4'd2;
    localparam logic [3:0] ST_CNT_LO  = 4'd3;
    localparam logic [3:0] ST_PAYLOAD = 4'd4;
    localparam logic [3:0] ST_WRITE   = 4'd5;
    localparam logic [3:0] ST_CSUM    = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

    // True while a frame is being received; only then may the idle timer run.
    function automatic logic in_frame(input logic [3:0] st);
        return (st >= ST_SYNC1) && (st <= ST_CSUM);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Purpose: byte-stream input plus instruction-memory write port and load status of the loader.
// Latency: n/a (wiring only).
// Backpressure: rx_valid/rx_ready handshake; the imem side has no backpressure.
interface program_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) ();
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_opcode;
    logic [DATA_WIDTH-1:0] imem_operand;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    // Byte source and observer of the memory port / status.
    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_opcode, imem_operand,
               cpu_hold, load_done, load_error
    );

    // The loader itself.
    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_opcode, imem_operand,
               cpu_hold, load_done, load_error
    );
endinterface

// File: rtl/loader_timeout.sv
// Purpose: idle-cycle watchdog between accepted bytes of a frame.
// Latency: expired rises TIMEOUT_CYCLES-1 enabled cycles after the last clear.
// Backpressure: none; clear has priority, counter holds at zero while disabled.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expired = enable && (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count idle enabled cycles; restart on every accepted byte or when idle-disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expired) begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/program_loader.sv
// Purpose: parse framed program image bytes, write instruction words to imem, gate core reset.
// Latency: imem_we strobes the cycle after the last byte of a word; status updates on the CSUM byte edge.
// Backpressure: rx_ready drops for exactly the one WRITE cycle of each word.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int         DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int         ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter logic [7:0] MAGIC0         = MAGIC0_DEF,
    parameter logic [7:0] MAGIC1         = MAGIC1_DEF,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.slave bus
);
    localparam int          WORD_W   = 2 * DATA_WIDTH;
    localparam int          BPW      = WORD_W / 8;
    localparam int          IDXW     = $clog2(BPW);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

    logic [3:0]            state;
    logic [7:0]            count_hi;
    logic [15:0]           words_left;
    logic [IDXW-1:0]       byte_idx;
    logic [WORD_W-9:0]     asm_reg;
    logic [7:0]            csum;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_opcode;
    logic [DATA_WIDTH-1:0] imem_operand;
    logic                  cpu_hold;
    logic                  load_done;
    logic                  load_error;

    logic                  accept;
    logic                  expired;
    logic [16:0]           count_full;
    logic [WORD_W-1:0]     asm_next;

    assign bus.rx_ready     = (state != ST_WRITE);
    assign bus.imem_we      = (state == ST_WRITE);
    assign bus.imem_addr    = imem_addr;
    assign bus.imem_opcode  = imem_opcode;
    assign bus.imem_operand = imem_operand;
    assign bus.cpu_hold     = cpu_hold;
    assign bus.load_done    = load_done;
    assign bus.load_error   = load_error;

    assign accept     = bus.rx_valid && (state != ST_WRITE);
    assign count_full = {1'b0, count_hi, bus.rx_data};
    assign asm_next   = {asm_reg, bus.rx_data};

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (in_frame(state)),
        .expired(expired)
    );

    // Frame FSM with its datapath: count, word assembly, XOR checksum and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_SYNC0;
            count_hi     <= '0;
            words_left   <= '0;
            byte_idx     <= '0;
            asm_reg      <= '0;
            csum         <= '0;
            imem_addr    <= '0;
            imem_opcode  <= '0;
            imem_operand <= '0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else if (accept && bus.rx_data == MAGIC0 &&
                     (state == ST_SYNC0 || state == ST_DONE || state == ST_ERROR)) begin
            // Start of a new frame: hold the core and forget the previous status.
            state      <= ST_SYNC1;
            csum       <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else if (!accept && expired) begin
            state      <= ST_ERROR;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b1;
        end else begin
            case (state)
                ST_SYNC1: begin
                    if (accept) begin
                        if (bus.rx_data == MAGIC1) begin
                            state <= ST_CNT_HI;
                        end else if (bus.rx_data != MAGIC0) begin
                            state <= ST_SYNC0;
                        end
                    end
                end
                ST_CNT_HI: begin
                    if (accept) begin
                        count_hi <= bus.rx_data;
                        state    <= ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (accept) begin
                        if (count_full == 17'd0) begin
                            state <= ST_CSUM;
                        end else if (count_full > CAPACITY) begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end else begin
                            state      <= ST_PAYLOAD;
                            words_left <= count_full[15:0];
                            imem_addr  <= '0;
                            byte_idx   <= '0;
                            csum       <= '0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        csum <= csum ^ bus.rx_data;
                        if (byte_idx == IDXW'(BPW - 1)) begin
                            byte_idx     <= '0;
                            imem_opcode  <= asm_next[WORD_W-1:DATA_WIDTH];
                            imem_operand <= asm_next[DATA_WIDTH-1:0];
                            words_left   <= words_left - 16'd1;
                            state        <= ST_WRITE;
                        end else begin
                            asm_reg  <= asm_next[WORD_W-9:0];
                            byte_idx <= byte_idx + IDXW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    // Address advances only when another word follows, so it never wraps
                    // past the last slot of a full-capacity image.
                    if (words_left == 16'd0) begin
                        state <= ST_CSUM;
                    end else begin
                        state     <= ST_PAYLOAD;
                        imem_addr <= imem_addr + ADDR_WIDTH'(1);
                    end
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (bus.rx_data == csum) begin
                            state     <= ST_DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            state      <= ST_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                end
                ST_SYNC0, ST_DONE, ST_ERROR: begin
                    // Non-MAGIC0 bytes are dropped while hunting or parked.
                end
                default: begin
                    state    <= ST_SYNC0;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Purpose: randomized + directed check of program_loader against a frame-level reference model.
// Latency: checks writes on the strobe cycle, status on the negedge after the last byte.
// Backpressure: driver holds each byte until rx_ready is seen high.
module tb_program_loader;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    program_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    program_loader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] opc;
        logic [DW-1:0] opr;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  we_count = 0;
    int  ready_low_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
        logic [7:0] x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        return x;
    endfunction

    // Compare process: invariants every cycle, write scoreboard on every strobe.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("hold_vs_done", {31'd0, bus.cpu_hold}, {31'd0, ~bus.load_done});
            chk("ready_vs_we", {31'd0, bus.rx_ready}, {31'd0, ~bus.imem_we});
            chk("done_err_excl", {31'd0, bus.load_done & bus.load_error}, 32'd0);
            if (!bus.rx_ready) ready_low_count++;
            if (bus.imem_we) begin
                we_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h_%0h, none required",
                             bus.imem_addr, bus.imem_opcode, bus.imem_operand);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", {24'd0, bus.imem_addr}, {24'd0, w.addr});
                    chk("wr_word", {bus.imem_opcode, bus.imem_operand}, {w.opc, w.opr});
                end
            end
        end
    end

    // Present one byte after `gap` idle cycles; return right after its handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_stuck: got 0 required 1 within 20 cycles");
        end
        @(posedge clk);
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
        foreach (q[i]) send_byte(q[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    endtask

    task automatic check_status(input string tag, input bit done, input bit err);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, bus.load_done}, {31'd0, done});
        chk({tag, "_error"}, {31'd0, bus.load_error}, {31'd0, err});
        chk({tag, "_hold"}, {31'd0, bus.cpu_hold}, {31'd0, ~done});
        chk({tag, "_pending_writes"}, exp_q.size(), 32'd0);
    endtask

    // Build a frame of n words from random payload, queue the writes it must cause, send it.
    task automatic random_frame(input int n, input bit bad, input int maxgap, input string tag);
        logic [7:0] pay[$];
        logic [7:0] fr[$];
        logic [7:0] cs;
        for (int i = 0; i < n * 4; i++) pay.push_back(8'($urandom));
        for (int w = 0; w < n; w++)
            exp_q.push_back({AW'(w), pay[4*w], pay[4*w+1], pay[4*w+2], pay[4*w+3]});
        cs = xor_of(pay);
        if (bad) cs = cs ^ 8'($urandom_range(1, 255));
        fr = {8'hA5, 8'h5A, 8'(n >> 8), 8'(n)};
        fr = {fr, pay, cs};
        send_bytes(fr, maxgap);
        check_status(tag, !bad, bad);
    endtask

    task automatic push_ref_words();
        exp_q.push_back({8'd0, 16'h1001, 16'h0005});
        exp_q.push_back({8'd1, 16'h7002, 16'h0000});
    endtask

    logic [7:0] ref_pay[$];
    logic [7:0] q[$];
    int         base_we;
    int         base_rl;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #22;
        chk("rst_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("rst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("rst_addr", {24'd0, bus.imem_addr}, 32'd0);
        chk("rst_word", {bus.imem_opcode, bus.imem_operand}, 32'd0);
        chk("rst_hold", {31'd0, bus.cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, bus.load_done}, 32'd0);
        chk("rst_error", {31'd0, bus.load_error}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reference frame: payload XOR is 0x66 by hand.
        ref_pay = {8'h10, 8'h01, 8'h00, 8'h05, 8'h70, 8'h02, 8'h00, 8'h00};
        chk("model_xor", {24'd0, xor_of(ref_pay)}, 32'h66);
        push_ref_words();
        q = {8'hA5, 8'h5A, 8'h00, 8'h02, ref_pay, 8'h66};
        send_bytes(q, 2);
        check_status("ref_good", 1'b1, 1'b0);

        push_ref_words();
        q = {8'hA5, 8'h5A, 8'h00, 8'h02, ref_pay, 8'h67};
        send_bytes(q, 0);
        check_status("ref_badcsum", 1'b0, 1'b1);

        // Leading garbage and a repeated sync byte, then an empty image.
        q = {8'h00, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
        send_bytes(q, 1);
        check_status("empty_image", 1'b1, 1'b0);

        // One word over capacity: rejected on the count byte, nothing written.
        q = {8'hA5, 8'h5A, 8'h01, 8'h01};
        send_bytes(q, 0);
        check_status("over_capacity", 1'b0, 1'b1);
        send_byte(8'h3C, 0);
        check_status("error_ignores", 1'b0, 1'b1);

        // Stall mid-payload: one word written, second word starved.
        exp_q.push_back({8'd0, 16'h1122, 16'h3344});
        q = {8'hA5, 8'h5A, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_bytes(q, 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("timeout_not_yet", {31'd0, bus.load_error}, 32'd0);
        @(negedge clk);
        chk("timeout_fired", {31'd0, bus.load_error}, 32'd1);
        chk("timeout_hold", {31'd0, bus.cpu_hold}, 32'd1);
        push_ref_words();
        q = {8'hA5, 8'h5A, 8'h00, 8'h02, ref_pay, 8'h66};
        send_bytes(q, 0);
        check_status("after_timeout", 1'b1, 1'b0);

        // Full-capacity image streamed back to back: one ready-low cycle per word.
        base_we = we_count;
        base_rl = ready_low_count;
        random_frame(1 << AW, 1'b0, 0, "full_capacity");
        chk("full_we_pulses", we_count - base_we, 32'd256);
        chk("full_ready_low", ready_low_count - base_rl, 32'd256);

        // Randomized frames with garbage prefixes, gaps and corrupted checksums.
        for (int it = 0; it < 20; it++) begin
            int ng;
            ng = $urandom_range(0, 3);
            for (int g = 0; g < ng; g++) begin
                logic [7:0] gb;
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h00;
                send_byte(gb, $urandom_range(0, 2));
            end
            random_frame($urandom_range(0, 6), ($urandom_range(0, 3) == 0), 3, "rand");
        end

        // Reset during the second word of a continuous stream.
        exp_q.push_back({8'd0, 16'hDEAD, 16'hBEEF});
        q = {8'hA5, 8'h5A, 8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        send_bytes(q, 0);
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, bus.rx_ready}, 32'd1);
        chk("midrst_we", {31'd0, bus.imem_we}, 32'd0);
        chk("midrst_addr", {24'd0, bus.imem_addr}, 32'd0);
        chk("midrst_word", {bus.imem_opcode, bus.imem_operand}, 32'd0);
        chk("midrst_hold", {31'd0, bus.cpu_hold}, 32'd1);
        chk("midrst_flags", {30'd0, bus.load_done, bus.load_error}, 32'd0);
        chk("midrst_pending", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_ref_words();
        q = {8'hA5, 8'h5A, 8'h00, 8'h02, ref_pay, 8'h66};
        send_bytes(q, 1);
        check_status("after_reset", 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
